// File: rtl/control_sequencer_if.sv
// control_sequencer_if: control bundle between control_sequencer (master) and datapath (slave).
interface control_sequencer_if #(parameter int OPC_W = 5);
    logic [31:0]      IR_Data;
    logic             PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable;
    logic             MAR_enable, MDR_enable, r_enable, read, write;
    logic             Gra, Grb, ba_select;
    logic             PC_select, Z_LO_select, MDR_select, c_select, r_select;
    logic [OPC_W-1:0] alu_instruction;
    modport master (
        input  IR_Data,
        output PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable,
               MAR_enable, MDR_enable, r_enable, read, write, Gra, Grb, ba_select,
               PC_select, Z_LO_select, MDR_select, c_select, r_select, alu_instruction
    );
    modport slave (
        output IR_Data,
        input  PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable,
               MAR_enable, MDR_enable, r_enable, read, write, Gra, Grb, ba_select,
               PC_select, Z_LO_select, MDR_select, c_select, r_select, alu_instruction
    );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute control unit, one clock per step T0-T7.
module control_sequencer #(
    parameter int OPC_W = 5,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    control_sequencer_if.master bus,
    input  logic                stop,
    input  logic                resume,
    output logic                run,
    output logic                illegal_op,
    output logic [CNT_W-1:0]    instr_count
);
    typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
    localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;
    state_t           state, next;
    logic             armed, last, illegal;
    logic [OPC_W-1:0] opc;
    assign opc = bus.IR_Data[31 -: OPC_W];
    assign illegal = !(opc inside {OP_LD, OP_LDI, OP_ST, OP_ADDI, OP_NOP, OP_HALT});
    assign run = state != IDLE && state != HALT;
    assign bus.PC_enable = 1'b0;
    // armed delays the first T0 to the second edge after reset release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            armed       <= 1'b0;
            illegal_op  <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= next;
            armed <= 1'b1;
            if (state == T3 && illegal) illegal_op <= 1'b1;
            if (last) instr_count <= instr_count + CNT_W'(1);
        end
    end
    always_comb begin
        next = state;
        last = 1'b0;
        bus.PC_increment_enable = 1'b0;
        bus.IR_enable = 1'b0;
        bus.Y_enable = 1'b0;
        bus.Z_enable = 1'b0;
        bus.MAR_enable = 1'b0;
        bus.MDR_enable = 1'b0;
        bus.r_enable = 1'b0;
        bus.read = 1'b0;
        bus.write = 1'b0;
        bus.Gra = 1'b0;
        bus.Grb = 1'b0;
        bus.ba_select = 1'b0;
        bus.PC_select = 1'b0;
        bus.Z_LO_select = 1'b0;
        bus.MDR_select = 1'b0;
        bus.c_select = 1'b0;
        bus.r_select = 1'b0;
        bus.alu_instruction = '0;
        case (state)
            IDLE: next = armed ? T0 : IDLE;
            T0: begin
                bus.PC_select = 1'b1;
                bus.MAR_enable = 1'b1;
                next = T1;
            end
            T1: begin
                bus.PC_increment_enable = 1'b1;
                bus.read = 1'b1;
                bus.MDR_enable = 1'b1;
                next = T2;
            end
            T2: begin
                bus.MDR_select = 1'b1;
                bus.IR_enable = 1'b1;
                next = T3;
            end
            T3: begin
                if (opc == OP_HALT) next = HALT;
                else if (opc inside {OP_LD, OP_LDI, OP_ST, OP_ADDI}) begin
                    bus.Grb = 1'b1;
                    bus.Y_enable = 1'b1;
                    bus.ba_select = opc != OP_ADDI;
                    bus.r_select = opc == OP_ADDI;
                    next = T4;
                end else last = 1'b1;
            end
            T4: begin
                bus.c_select = 1'b1;
                bus.Z_enable = 1'b1;
                bus.alu_instruction = opc;
                next = T5;
            end
            T5: begin
                bus.Z_LO_select = 1'b1;
                if (opc == OP_LD || opc == OP_ST) begin
                    bus.MAR_enable = 1'b1;
                    next = T6;
                end else begin
                    bus.Gra = 1'b1;
                    bus.r_enable = 1'b1;
                    last = 1'b1;
                end
            end
            T6: begin
                bus.MDR_enable = 1'b1;
                if (opc == OP_ST) begin
                    bus.Gra = 1'b1;
                    bus.r_select = 1'b1;
                    bus.write = 1'b1;
                    last = 1'b1;
                end else begin
                    bus.read = 1'b1;
                    next = T7;
                end
            end
            T7: begin
                bus.MDR_select = 1'b1;
                bus.Gra = 1'b1;
                bus.r_enable = 1'b1;
                last = 1'b1;
            end
            HALT: next = resume ? T0 : HALT;
            default: next = IDLE;
        endcase
        if (last) next = stop ? HALT : T0;
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed checks of per-step control vectors, halt/stop/resume, reset and count wrap.
module tb_control_sequencer;
    localparam logic [17:0] PCE = 18'd1 << 17, PCI = 18'd1 << 16, IRE = 18'd1 << 15, YE = 18'd1 << 14;
    localparam logic [17:0] ZE = 18'd1 << 13, MARE = 18'd1 << 12, MDRE = 18'd1 << 11, RE = 18'd1 << 10;
    localparam logic [17:0] RD = 18'd1 << 9, WR = 18'd1 << 8, GRA = 18'd1 << 7, GRB = 18'd1 << 6;
    localparam logic [17:0] BA = 18'd1 << 5, PCS = 18'd1 << 4, ZLO = 18'd1 << 3, MDRS = 18'd1 << 2;
    localparam logic [17:0] CS = 18'd1 << 1, RS = 18'd1 << 0;
    localparam logic [17:0] F0 = PCS | MARE, F1 = PCI | RD | MDRE, F2 = MDRS | IRE;
    localparam logic [31:0] LDI_I  = {5'b00001, 4'd4, 4'd0, 19'h65};
    localparam logic [31:0] ST_I   = {5'b00010, 4'd4, 4'd4, 19'h1F};
    localparam logic [31:0] LD_I   = {5'b00000, 4'd2, 4'd0, 19'h54};
    localparam logic [31:0] ADDI_I = {5'b01100, 4'd1, 4'd2, 19'h7};
    localparam logic [31:0] NOP_I  = {5'b11010, 27'd0};
    localparam logic [31:0] HALT_I = {5'b11011, 27'd0};
    localparam logic [31:0] ILL_I  = {5'b10101, 27'd0};

    logic        clk, reset_n, stop, resume, run, illegal_op, run2, illegal2;
    logic [15:0] instr_count;
    logic [1:0]  cnt2;
    logic [31:0] ir;
    logic [17:0] ctl;
    int          passed = 0, total = 0;

    control_sequencer_if bus ();
    control_sequencer_if bus2 ();
    assign bus.IR_Data = ir;
    assign bus2.IR_Data = ir;
    assign ctl = {bus.PC_enable, bus.PC_increment_enable, bus.IR_enable, bus.Y_enable, bus.Z_enable,
                  bus.MAR_enable, bus.MDR_enable, bus.r_enable, bus.read, bus.write, bus.Gra, bus.Grb,
                  bus.ba_select, bus.PC_select, bus.Z_LO_select, bus.MDR_select, bus.c_select, bus.r_select};

    control_sequencer dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .stop(stop), .resume(resume),
        .run(run), .illegal_op(illegal_op), .instr_count(instr_count)
    );
    // narrow-counter twin in lockstep, used to observe counter wrap
    control_sequencer #(.CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2), .stop(stop), .resume(resume),
        .run(run2), .illegal_op(illegal2), .instr_count(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset_n = 1'b0; stop = 1'b0; resume = 1'b0; ir = '0;
        repeat (2) @(negedge clk);
        total++;
        if (ctl !== '0 || bus.alu_instruction !== 5'd0) $display("FAIL reset_outputs ctl=%h alu=%b want 0", ctl, bus.alu_instruction);
        else passed++;
        total++;
        if (run !== 1'b0 || illegal_op !== 1'b0 || instr_count !== 16'd0)
            $display("FAIL reset_status run=%b ill=%b cnt=%0d want 0 0 0", run, illegal_op, instr_count);
        else passed++;
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (run !== 1'b0) $display("FAIL reset_idle_first_edge run=%b want 0", run);
        else passed++;
        @(negedge clk);
        total++;
        if (run !== 1'b1 || ctl !== F0) $display("FAIL reset_first_t0 run=%b ctl=%h want 1 %h", run, ctl, F0);
        else passed++;
    endtask

    task automatic test_program();
        logic [17:0] v [13];
        logic [4:0]  a [13];
        v = '{F0, F1, F2, GRB | BA | YE, CS | ZE, ZLO | GRA | RE,
              F0, F1, F2, GRB | BA | YE, CS | ZE, ZLO | MARE, GRA | RS | WR | MDRE};
        a = '{5'd0, 5'd0, 5'd0, 5'd0, 5'b00001, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b00010, 5'd0, 5'd0};
        ir = LDI_I;
        for (int i = 0; i < 13; i++) begin
            if (i == 6) ir = ST_I;
            total++;
            if (ctl !== v[i] || bus.alu_instruction !== a[i] || run !== 1'b1)
                $display("FAIL program_step%0d ctl=%h alu=%b run=%b want %h %b 1", i, ctl, bus.alu_instruction, run, v[i], a[i]);
            else passed++;
            @(negedge clk);
        end
        total++;
        if (instr_count !== 16'd2 || ctl !== F0) $display("FAIL program_count cnt=%0d ctl=%h want 2 %h", instr_count, ctl, F0);
        else passed++;
    endtask

    task automatic test_ld();
        logic [17:0] v [8];
        v = '{F0, F1, F2, GRB | BA | YE, CS | ZE, ZLO | MARE, RD | MDRE, MDRS | GRA | RE};
        ir = LD_I;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (ctl !== v[i] || bus.alu_instruction !== 5'd0)
                $display("FAIL ld_step%0d ctl=%h alu=%b want %h 00000", i, ctl, bus.alu_instruction, v[i]);
            else passed++;
            @(negedge clk);
        end
        total++;
        if (instr_count !== 16'd3 || ctl !== F0) $display("FAIL ld_count cnt=%0d ctl=%h want 3 %h", instr_count, ctl, F0);
        else passed++;
    endtask

    task automatic test_illegal();
        logic [17:0] v [4];
        v = '{F0, F1, F2, 18'd0};
        ir = ILL_I;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (ctl !== v[i] || illegal_op !== 1'b0)
                $display("FAIL illegal_step%0d ctl=%h ill=%b want %h 0", i, ctl, illegal_op, v[i]);
            else passed++;
            @(negedge clk);
        end
        total++;
        if (illegal_op !== 1'b1 || instr_count !== 16'd4 || ctl !== F0)
            $display("FAIL illegal_after ill=%b cnt=%0d ctl=%h want 1 4 %h", illegal_op, instr_count, ctl, F0);
        else passed++;
        ir = NOP_I;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (ctl !== v[i]) $display("FAIL nop_step%0d ctl=%h want %h", i, ctl, v[i]);
            else passed++;
            @(negedge clk);
        end
        total++;
        if (illegal_op !== 1'b1 || instr_count !== 16'd5 || ctl !== F0)
            $display("FAIL illegal_sticky ill=%b cnt=%0d ctl=%h want 1 5 %h", illegal_op, instr_count, ctl, F0);
        else passed++;
    endtask

    task automatic test_halt();
        ir = HALT_I;
        repeat (4) @(negedge clk);
        total++;
        if (run !== 1'b0 || ctl !== '0 || instr_count !== 16'd5)
            $display("FAIL halt_enter run=%b ctl=%h cnt=%0d want 0 0 5", run, ctl, instr_count);
        else passed++;
        stop = 1'b1;
        @(negedge clk);
        total++;
        if (run !== 1'b0) $display("FAIL halt_stay run=%b want 0", run);
        else passed++;
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0; stop = 1'b0;
        total++;
        if (run !== 1'b1 || ctl !== F0) $display("FAIL halt_resume run=%b ctl=%h want 1 %h", run, ctl, F0);
        else passed++;
    endtask

    task automatic test_stop();
        logic [17:0] v [4];
        v = '{F2, GRB | BA | YE, CS | ZE, ZLO | GRA | RE};
        ir = LDI_I;
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (ctl !== v[i] || run !== 1'b1) $display("FAIL stop_step%0d ctl=%h run=%b want %h 1", i, ctl, run, v[i]);
            else passed++;
            @(negedge clk);
        end
        total++;
        if (run !== 1'b0 || ctl !== '0 || instr_count !== 16'd6)
            $display("FAIL stop_halt run=%b ctl=%h cnt=%0d want 0 0 6", run, ctl, instr_count);
        else passed++;
        stop = 1'b0;
        @(negedge clk);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        total++;
        if (ctl !== F0) $display("FAIL stop_resume ctl=%h want %h", ctl, F0);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [17:0] v [5];
        v = '{F0, F1, F2, GRB | RS | YE, CS | ZE};
        ir = ADDI_I;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (ctl !== v[i] || bus.alu_instruction !== (i == 4 ? 5'b01100 : 5'd0))
                $display("FAIL addi_step%0d ctl=%h alu=%b want %h", i, ctl, bus.alu_instruction, v[i]);
            else passed++;
            if (i < 4) @(negedge clk);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (ctl !== '0 || bus.alu_instruction !== 5'd0 || run !== 1'b0)
            $display("FAIL async_reset_outputs ctl=%h alu=%b run=%b want 0 0 0", ctl, bus.alu_instruction, run);
        else passed++;
        total++;
        if (instr_count !== 16'd0 || illegal_op !== 1'b0)
            $display("FAIL async_reset_status cnt=%0d ill=%b want 0 0", instr_count, illegal_op);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (run !== 1'b0) $display("FAIL reset_mid_idle run=%b want 0", run);
        else passed++;
        @(negedge clk);
        total++;
        if (run !== 1'b1 || ctl !== F0) $display("FAIL reset_mid_t0 run=%b ctl=%h want 1 %h", run, ctl, F0);
        else passed++;
    endtask

    task automatic test_wrap();
        ir = NOP_I;
        repeat (12) @(negedge clk);
        total++;
        if (instr_count !== 16'd3 || cnt2 !== 2'd3 || ctl !== F0)
            $display("FAIL wrap_preset cnt=%0d cnt2=%0d ctl=%h want 3 3 %h", instr_count, cnt2, ctl, F0);
        else passed++;
        ir = LDI_I;
        @(negedge clk);
        stop = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (cnt2 !== 2'd0 || instr_count !== 16'd4 || run !== 1'b0 || run2 !== 1'b0)
            $display("FAIL wrap cnt2=%0d cnt=%0d run=%b run2=%b want 0 4 0 0", cnt2, instr_count, run, run2);
        else passed++;
        stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_program();
        test_ld();
        test_illegal();
        test_halt();
        test_stop();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout passed=%0d total=%0d", passed, total);
        $fatal(1);
    end
endmodule
